row_stream_ctrl: RTL

Sequencer between the row loader and the CNN accelerator input. It requests 480-bit image rows from the loader one at a time, splits each accepted row into 16-bit words, and streams the words to the accelerator with a valid/ready handshake. It counts rows per image, pauses at row boundaries on `interrupt`, and flags end-of-image to the loader (`stop`) and to the host (`done`).

---
 rtl/row_stream_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/row_stream_ctrl.sv
// row_stream_ctrl: requests image rows from the loader one at a time, splits
// each row into words and streams them to the accelerator over valid/ready.
// Pauses between rows while interrupt is high and flags end of image.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for load_process, all outputs low
// REQ    | one-cycle send pulse asking the loader for the next row
// WAIT   | row_ready high, waiting for the row handshake
// STREAM | presenting shreg low word until the last word is accepted
// PAUSE  | between rows, held while interrupt is high
// DONE   | image complete, done/stop high until load_process drops
module row_stream_ctrl #(
    parameter int ROW_W    = 480,
    parameter int WORD_W   = 16,
    parameter int NUM_ROWS = 32,
    parameter int CNT_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_process,
    input  logic              interrupt,
    input  logic [ROW_W-1:0]  row_in,
    input  logic              row_valid,
    output logic              row_ready,
    output logic              send,
    output logic              stop,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  row_idx,
    output logic              done
);

    localparam int WORDS = ROW_W / WORD_W;
    localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_STREAM,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  row_idx_q, row_idx_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [ROW_W-1:0]  shreg_q, shreg_d;

    // State, row counter, word counter and shift register; reset discards any partial row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_idx_q  <= '0;
            word_cnt_q <= '0;
            shreg_q    <= '0;
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            word_cnt_q <= word_cnt_d;
            shreg_q    <= shreg_d;
        end
    end

    // Next-state and Moore outputs; word_out is forced low whenever no word is offered.
    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        word_cnt_d = word_cnt_q;
        shreg_d    = shreg_q;
        send       = 1'b0;
        row_ready  = 1'b0;
        word_valid = 1'b0;
        word_out   = '0;
        done       = 1'b0;
        stop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_process) begin
                    row_idx_d = '0;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                send    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                row_ready = 1'b1;
                if (row_valid) begin
                    shreg_d    = row_in;
                    word_cnt_d = '0;
                    state_d    = S_STREAM;
                end
            end
            S_STREAM: begin
                word_valid = 1'b1;
                word_out   = shreg_q[WORD_W-1:0];
                if (word_ready) begin
                    shreg_d    = shreg_q >> WORD_W;
                    word_cnt_d = word_cnt_q + WC_W'(1);
                    if (word_cnt_q == LAST_WORD) begin
                        // interrupt only matters here, so a row is never cut short
                        if (row_idx_q == LAST_ROW) begin
                            state_d = S_DONE;
                        end else begin
                            row_idx_d = row_idx_q + CNT_W'(1);
                            state_d   = interrupt ? S_PAUSE : S_REQ;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (!interrupt) begin
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                done = 1'b1;
                stop = 1'b1;
                if (!load_process) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign row_idx = row_idx_q;

endmodule
